// File: rtl/div_share_sched.sv
// div_share_sched: round-robin scheduler sharing one multi-cycle divider
// among NUM_REQ ratio requesters. It handles one operation at a time, and
// zero divisors are answered directly without using the divider.
// Optional macro DIV_SCHED_TIMEOUT_EN adds a WAIT-state watchdog: after
// TIMEOUT cycles with no result, it responds with error=1 and quotient=0.
module div_share_sched #(
   parameter  int NUM_REQ    = 4,
   parameter  int DIVIDEND_W = 22,
   parameter  int DIVISOR_W  = 21,
   parameter  int QUOTIENT_W = 33,
   parameter  int TIMEOUT    = 64,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [NUM_REQ-1:0]              req_valid_in,
   output logic [NUM_REQ-1:0]              req_ready_out,
   input  logic [NUM_REQ*DIVIDEND_W-1:0]   req_dividend_in,
   input  logic [NUM_REQ*DIVISOR_W-1:0]    req_divisor_in,
   output logic                            resp_valid_out,
   input  logic                            resp_ready_in,
   output logic [ID_W-1:0]                 resp_id_out,
   output logic [QUOTIENT_W-1:0]           resp_quotient_out,
   output logic                            resp_error_out,
   output logic [DIVIDEND_W-1:0]           div_dividend_out,
   output logic [DIVISOR_W-1:0]            div_divisor_out,
   output logic                            div_valid_out,
   input  logic [QUOTIENT_W-1:0]           div_quotient_in,
   input  logic                            div_valid_in
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

   state_t                  state, state_nxt;
   logic [ID_W-1:0]         last_grant;
   logic [ID_W-1:0]         win_id;
   logic                    win_vld;
   logic [DIVIDEND_W-1:0]   op_dividend;
   logic [DIVISOR_W-1:0]    op_divisor;
   logic [ID_W-1:0]         rsp_id;
   logic [QUOTIENT_W-1:0]   rsp_q;
   logic                    rsp_err;
   logic                    wait_expired;

   // unpack per-requester operand slices
   logic [DIVIDEND_W-1:0]   dvd_arr [NUM_REQ];
   logic [DIVISOR_W-1:0]    dvs_arr [NUM_REQ];
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign dvd_arr[g] = req_dividend_in[g*DIVIDEND_W +: DIVIDEND_W];
      assign dvs_arr[g] = req_divisor_in[g*DIVISOR_W +: DIVISOR_W];
   end

   logic win_zero;
   assign win_zero = (dvs_arr[win_id] == '0);

   // round-robin search from last_grant+1; scanning far-to-near lets the nearest valid requester win
   always_comb begin
      logic [ID_W:0] sum;
      win_vld = 1'b0;
      win_id  = '0;
      sum     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sum = {1'b0, last_grant} + (ID_W+1)'(k);
         if (sum >= NREQ) sum = sum - NREQ;
         if (req_valid_in[sum[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = sum[ID_W-1:0];
         end
      end
   end

`ifdef DIV_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT+1);
   logic [TO_W-1:0] wait_cnt;

   // watchdog counts WAIT cycles, cleared in every other state
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)              wait_cnt <= '0;
      else if (state != WAIT)  wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + 1'b1;
   end

   assign wait_expired = (wait_cnt == TO_W'(TIMEOUT-1));
`else
   assign wait_expired = 1'b0;
`endif

   // state register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; grant is combinational and only in IDLE
   always_comb begin
      state_nxt     = state;
      req_ready_out = '0;
      case (state)
         IDLE: if (win_vld) begin
            req_ready_out[win_id] = 1'b1;
            state_nxt = win_zero ? RESP : ISSUE;
         end
         ISSUE: state_nxt = WAIT;
         WAIT:  if (div_valid_in || wait_expired) state_nxt = RESP;
         RESP:  if (resp_ready_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // operand/response capture; a divider result only counts while in WAIT
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_grant  <= ID_W'(NUM_REQ-1);
         op_dividend <= '0;
         op_divisor  <= '0;
         rsp_id      <= '0;
         rsp_q       <= '0;
         rsp_err     <= 1'b0;
      end else begin
         if (state == IDLE && win_vld) begin
            last_grant  <= win_id;
            rsp_id      <= win_id;
            op_dividend <= dvd_arr[win_id];
            op_divisor  <= dvs_arr[win_id];
            if (win_zero) begin
               rsp_q   <= '1;
               rsp_err <= 1'b1;
            end
         end
         if (state == WAIT) begin
            if (div_valid_in) begin
               rsp_q   <= div_quotient_in;
               rsp_err <= 1'b0;
            end else if (wait_expired) begin
               rsp_q   <= '0;
               rsp_err <= 1'b1;
            end
         end
      end
   end

   assign div_valid_out     = (state == ISSUE);
   assign div_dividend_out  = op_dividend;
   assign div_divisor_out   = op_divisor;
   assign resp_valid_out    = (state == RESP);
   assign resp_id_out       = rsp_id;
   assign resp_quotient_out = rsp_q;
   assign resp_error_out    = rsp_err;

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a behavioural divider of
// programmable latency. It includes the watchdog case when DIV_SCHED_TIMEOUT_EN
// is defined.
module tb_div_share_sched;
   localparam int NR = 4, DW = 22, SW = 21, QW = 33, TO = 8;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic [NR-1:0]     req_valid_in, req_ready_out;
   logic [NR*DW-1:0]  req_dividend_in;
   logic [NR*SW-1:0]  req_divisor_in;
   logic              resp_valid_out, resp_ready_in;
   logic [1:0]        resp_id_out;
   logic [QW-1:0]     resp_quotient_out;
   logic              resp_error_out;
   logic [DW-1:0]     div_dividend_out;
   logic [SW-1:0]     div_divisor_out;
   logic              div_valid_out;
   logic [QW-1:0]     div_quotient_in;
   logic              div_valid_in;

   div_share_sched #(.NUM_REQ(NR), .DIVIDEND_W(DW), .DIVISOR_W(SW),
                     .QUOTIENT_W(QW), .TIMEOUT(TO)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_dividend_in(req_dividend_in), .req_divisor_in(req_divisor_in),
      .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
      .resp_id_out(resp_id_out), .resp_quotient_out(resp_quotient_out),
      .resp_error_out(resp_error_out),
      .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
      .div_valid_out(div_valid_out),
      .div_quotient_in(div_quotient_in), .div_valid_in(div_valid_in));

   always #5 clk_in = ~clk_in;

   // divider model: result pulse arrives lat cycles after the issue cycle
   int          dcnt = 0;
   int          lat = 3;
   bit          silent = 1'b0;
   logic [QW-1:0] dq = '0;
   always @(posedge clk_in) begin
      if (div_valid_out && !silent) begin
         dcnt <= lat;
         dq   <= QW'(div_dividend_out / DW'(div_divisor_out));
      end else if (dcnt > 0) dcnt <= dcnt - 1;
   end
   assign div_valid_in    = (dcnt == 1);
   assign div_quotient_in = dq;

   int n_chk = 0, n_pass = 0;
   localparam logic [QW-1:0] ONES = '1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(negedge clk_in); #1;
   endtask

   task automatic set_req(input int i, input int dvd, input int dvs);
      req_dividend_in[i*DW +: DW] = DW'(dvd);
      req_divisor_in[i*SW +: SW]  = SW'(dvs);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen;
      int ord[5]  = '{2, 3, 0, 1, 2};
      int qexp[4] = '{333, 285, 272, 307};

      rst_in = 1'b1; req_valid_in = '0; req_dividend_in = '0; req_divisor_in = '0;
      resp_ready_in = 1'b0;
      tick; tick;
      // reset state
      chk("rst_ready", req_ready_out, 0);
      chk("rst_rvalid", resp_valid_out, 0);
      chk("rst_dvalid", div_valid_out, 0);
      chk("rst_id", resp_id_out, 0);
      chk("rst_q", resp_quotient_out, 0);
      chk("rst_err", resp_error_out, 0);
      chk("rst_ops", {div_dividend_out, div_divisor_out}, 0);
      rst_in = 1'b0; tick;

      // single requester 1, 570/10, latency 20
      lat = 20; set_req(1, 570, 10); req_valid_in = 4'b0010; #1;
      chk("t1_ready", req_ready_out, 4'b0010);
      tick; req_valid_in = '0;
      chk("t1_dvalid", div_valid_out, 1);
      chk("t1_dvd", div_dividend_out, 570);
      chk("t1_dvs", div_divisor_out, 10);
      chk("t1_noready", req_ready_out, 0);
      tick;
      chk("t1_issue_once", div_valid_out, 0);
      n = 1;
      while (!div_valid_in && n < 100) begin tick; n++; end
      chk("t1_lat", n, 20);
      chk("t1_resp_early", resp_valid_out, 0);
      tick;
      chk("t1_rvalid", resp_valid_out, 1);
      chk("t1_id", resp_id_out, 1);
      chk("t1_q", resp_quotient_out, 57);
      chk("t1_err", resp_error_out, 0);
      resp_ready_in = 1'b1; tick;
      chk("t1_done", resp_valid_out, 0);

      // all requesters valid: round robin continues from last grant (1)
      lat = 3;
      set_req(0, 1000, 3); set_req(1, 2000, 7); set_req(2, 3000, 11); set_req(3, 4000, 13);
      req_valid_in = 4'hf; #1;
      for (int g = 0; g < 5; g++) begin
         n = 0;
         while (req_ready_out == '0 && n < 50) begin tick; n++; end
         chk("t2_grant", req_ready_out, 64'(1) << ord[g]);
         n = 0;
         while (!resp_valid_out && n < 50) begin tick; n++; end
         chk("t2_id", resp_id_out, ord[g]);
         chk("t2_q", resp_quotient_out, qexp[ord[g]]);
         tick;
      end
      req_valid_in = '0;

      // requester 2 divisor 0: immediate error response, divider untouched
      set_req(2, 55, 0); req_valid_in = 4'b0100; resp_ready_in = 1'b0; #1;
      chk("t3_ready", req_ready_out, 4'b0100);
      tick; req_valid_in = 4'b0001;
      chk("t3_dvalid", div_valid_out, 0);
      chk("t3_rvalid", resp_valid_out, 1);
      chk("t3_id", resp_id_out, 2);
      chk("t3_q", resp_quotient_out, ONES);
      chk("t3_err", resp_error_out, 1);

      // back-pressure: response held, no grants while requester 0 waits
      for (int c = 0; c < 10; c++) begin
         tick;
         chk("t4_hold", {resp_valid_out, resp_id_out, resp_error_out, |req_ready_out,
                         resp_quotient_out}, {1'b1, 2'd2, 1'b1, 1'b0, ONES});
      end
      resp_ready_in = 1'b1; tick;
      chk("t4_accept", req_ready_out, 4'b0001);
      chk("t4_rdone", resp_valid_out, 0);
      tick; req_valid_in = '0;
      n = 0;
      while (!resp_valid_out && n < 50) begin tick; n++; end
      chk("t4_id", resp_id_out, 0);
      chk("t4_q", resp_quotient_out, 333);
      tick;

      // reset during WAIT, late divider pulse must be ignored
      lat = 10; req_valid_in = 4'b1000; #1;
      chk("t5_ready", req_ready_out, 4'b1000);
      tick; req_valid_in = '0;
      tick; tick;
      rst_in = 1'b1; #1;
      chk("t5_rst_ctl", {resp_valid_out, div_valid_out, req_ready_out, resp_id_out,
                         resp_error_out}, 0);
      chk("t5_rst_data", {resp_quotient_out, div_dividend_out, div_divisor_out}, 0);
      tick; rst_in = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick;
         if (resp_valid_out || div_valid_out) seen = 1'b1;
      end
      chk("t5_no_resp", seen, 0);
      set_req(2, 3000, 11);
      req_valid_in = 4'hf; #1;
      chk("t5_first", req_ready_out, 4'b0001);

`ifdef DIV_SCHED_TIMEOUT_EN
      // silent divider: watchdog answers TIMEOUT cycles after WAIT entry
      silent = 1'b1;
      tick; req_valid_in = '0;
      tick;
      n = 0;
      while (!resp_valid_out && n < 100) begin tick; n++; end
      chk("t6_lat", n, TO);
      chk("t6_q", resp_quotient_out, 0);
      chk("t6_err", resp_error_out, 1);
      chk("t6_id", resp_id_out, 0);
`else
      lat = 3;
      tick; req_valid_in = '0;
      n = 0;
      while (!resp_valid_out && n < 50) begin tick; n++; end
      chk("t6_id", resp_id_out, 0);
      chk("t6_q", resp_quotient_out, 333);
      chk("t6_err", resp_error_out, 0);
`endif
      tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
